alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request presents operation.
REQ-005 Port: in_ready  output  1  unit can accept request.
REQ-006 Port: ALUControl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0101 SLL, 0110 SUB, 1101 SRL, 1111 SRA.
REQ-007 Port: src_a  input  WIDTH  operand A / shift source.
REQ-008 Port: src_b  input  WIDTH  operand B / shift amount in low log2(WIDTH) bits.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: zero  output  1  result equals zero.
REQ-013 Port: illegal  output  1  ALUControl was not one of the eight defined codes.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept = in_valid & in_ready; ALUControl, src_a, src_b captured at accept; later input changes ignored.
REQ-016 Non-shift ops: IDLE -> DONE on accept; out_valid asserted cycle after accept (latency 1).
REQ-017 ADD/SUB modulo 2^WIDTH, carry/borrow discarded; AND/OR/XOR bitwise.
REQ-018 Shift amount = src_b[log2(WIDTH)-1:0]; upper bits of src_b ignored.
REQ-019 SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills MSBs with captured src_a[WIDTH-1].
REQ-020 Serial shift (macro absent): shamt = 0 -> IDLE -> DONE, result = src_a, latency 1; shamt = N > 0 -> IDLE -> SHIFT, one bit per cycle, down-counter loaded with N, SHIFT -> DONE on final bit; out_valid asserted N+1 cycles after accept.
REQ-021 Illegal ALUControl: IDLE -> DONE, result = 0, zero = 1, illegal = 1, latency 1.
REQ-022 result, zero, illegal held stable while out_valid = 1 and out_ready = 0.
REQ-023 DONE -> IDLE on out_ready = 1; in_ready rises the cycle after handoff (one result in flight, no back-to-back accept).
REQ-024 out_ready ignored outside DONE; in_valid ignored outside IDLE.
REQ-025 zero = (result == 0), registered with result; illegal = 0 for all defined codes.

Reset
REQ-026 rst sampled on clk rising edge; takes priority over all other events.
REQ-027 On reset: state IDLE, in_ready = 1 in following cycle, out_valid = 0, result = 0, zero = 0, illegal = 0, shift counter = 0.
REQ-028 Reset during SHIFT or DONE discards operation; no result delivered.

Configuration
REQ-029 Macro ALU_BARREL_SHIFT_EN: defined -> SLL/SRL/SRA computed in one cycle like other ops (latency 1 for all codes, SHIFT state never entered); undefined -> serial shifter per REQ-020.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 -> out_valid one cycle after accept, result 0x80000000, zero 0.
REQ-031 SUB 0x00000005 - 0x00000005 -> result 0x00000000, zero 1; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-032 SRA src_a 0x80000000, src_b 0x00000024 (shamt 4), serial build -> out_valid 5 cycles after accept, result 0xF8000000; barrel build -> 1 cycle.
REQ-033 SLL 0x1 by 0, out_ready held 0 for 3 cycles -> result 0x00000001 stable, in_ready 0, second in_valid ignored; in_ready 1 cycle after out_ready.
REQ-034 ALUControl 0100 -> result 0, zero 1, illegal 1; then AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, illegal 0.
REQ-035 SRL shamt 31 serial, rst asserted at cycle 10 -> out_valid never asserted, outputs 0, in_ready 1 cycle after reset release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-request ALU execution unit with serial or barrel shifter (ALU_BARREL_SHIFT_EN selects barrel)
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1111;

`ifdef ALU_BARREL_SHIFT_EN
    localparam logic SERIAL_SHIFT = 1'b0;
`else
    localparam logic SERIAL_SHIFT = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [SW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [SW-1:0]    shamt_in;
    logic             op_legal;
    logic             op_is_shift;
    logic             go_serial;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] shift_step;

    assign accept    = in_valid & in_ready;
    assign shamt_in  = src_b[SW-1:0];
    assign go_serial = SERIAL_SHIFT & op_legal & op_is_shift & (shamt_in != '0);

    // Classify the incoming opcode: legal at all, and whether it is a shift
    always_comb begin
        op_legal    = 1'b0;
        op_is_shift = 1'b0;
        case (ALUControl)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB: op_legal = 1'b1;
            OP_SLL, OP_SRL, OP_SRA: begin
                op_legal    = 1'b1;
                op_is_shift = 1'b1;
            end
            default: begin
                op_legal    = 1'b0;
                op_is_shift = 1'b0;
            end
        endcase
    end

    // Single-cycle result; in the serial build a shift only lands here when shamt is zero
    always_comb begin
        alu_out = '0;
        case (ALUControl)
            OP_AND: alu_out = src_a & src_b;
            OP_OR:  alu_out = src_a | src_b;
            OP_ADD: alu_out = src_a + src_b;
            OP_XOR: alu_out = src_a ^ src_b;
            OP_SUB: alu_out = src_a - src_b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: alu_out = src_a << shamt_in;
            OP_SRL: alu_out = src_a >> shamt_in;
            OP_SRA: alu_out = $unsigned($signed(src_a) >>> shamt_in);
`else
            OP_SLL, OP_SRL, OP_SRA: alu_out = src_a;
`endif
            default: alu_out = '0;
        endcase
    end

    // One-bit shift of the working value; SRA replicates the current MSB, which is the captured sign
    always_comb begin
        shift_step = result_q;
        case (op_q)
            OP_SLL:  shift_step = {result_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, result_q[WIDTH-1:1]};
            default: shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = go_serial ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one request in flight, handshake flags decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture at accept, step the shifter, hold while DONE
    always_comb begin
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = ALUControl;
                    illegal_d = ~op_legal;
                    if (!op_legal) begin
                        result_d = '0;
                        zero_d   = 1'b1;
                    end else if (go_serial) begin
                        result_d = src_a;
                        cnt_d    = shamt_in;
                        zero_d   = 1'b0;
                    end else begin
                        result_d = alu_out;
                        zero_d   = (alu_out == '0);
                    end
                end
            end
            SHIFT: begin
                result_d = shift_step;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    zero_d = (shift_step == '0);
                end
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1111;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctl = 4'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit seen   = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUControl(alu_ctl),
        .src_a(src_a),
        .src_b(src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int shlat(input int n);
        return (BARREL || n == 0) ? 1 : n + 1;
    endfunction

    // Monitor: compares every cycle a result is presented, pops on handoff
    always @(negedge clk) begin
        #1;
        if (sbq.size() == 0) begin
            chk("idle_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid) begin
            if (!seen) begin
                chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                seen = 1'b1;
            end
            chk("result", result, sbq[0].r);
            chk("zero", 32'(zero), 32'(sbq[0].z));
            chk("illegal", 32'(illegal), 32'(sbq[0].il));
            if (out_ready) begin
                void'(sbq.pop_front());
                seen = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic il, input int lat,
                        input bit push);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready %b want 1", in_ready);
        end
        alu_ctl  = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        if (push) sbq.push_back('{r, z, il, cyc, lat});
        @(negedge clk);
        in_valid = 1'b0;
        alu_ctl  = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_timeout: got in_ready %b want 1", in_ready);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic il, input int lat);
        send(op, a, b, r, z, il, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1);
        run(OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1);
        run(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run(OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, shlat(4));

        // Hold result with out_ready low; a second request must be ignored
        out_ready = 1'b0;
        send(OP_SLL, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            alu_ctl  = OP_ADD;
            src_a    = 32'h1234_5678;
            src_b    = 32'h1111_1111;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);

        run(4'b0100, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1);
        run(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1);
        run(OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1);
        run(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1);
        run(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
        run(OP_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1'b0, shlat(1));
        run(OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, shlat(31));
        run(OP_SRA, 32'h4000_0000, 32'hFFFF_FFE2, 32'h1000_0000, 1'b0, 1'b0, shlat(2));
        run(OP_SLL, 32'hFFFF_FFFF, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, shlat(31));
        run(4'b0111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
        run(OP_SRL, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, shlat(3));

        // Reset in the middle of a long shift: nothing must ever be delivered
        if (!BARREL) begin
            send(OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0, 1'b0, 1'b0, 0, 1'b0);
            for (int i = 0; i < 9; i++) begin
                chk("pre_rst_out_valid", 32'(out_valid), 32'd0);
                @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
            chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
            chk("mid_rst_result", result, 32'd0);
            chk("mid_rst_zero", 32'(zero), 32'd0);
            chk("mid_rst_illegal", 32'(illegal), 32'd0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                chk("post_rst_out_valid", 32'(out_valid), 32'd0);
            end
            run(OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
